// File: rtl/spi_fifo_param_if.sv
// Bus bundle for spi_fifo_param: push/pop handshake, control and status.
// master = the FIFO user side; slave = the FIFO itself.
interface spi_fifo_param_if #(
    parameter int DATA_WIDTH = 32,
    parameter int PTR_WIDTH  = 6
);
    logic                  wen;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ren;
    logic                  clear;
    logic                  flag_clr;
    logic [PTR_WIDTH:0]    thresh;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic                  full;
    logic                  empty;
    logic                  overflow;
    logic                  underflow;
    logic [PTR_WIDTH:0]    level;
    logic                  thresh_hit;

    modport master (
        output wen, wdata, ren, clear, flag_clr, thresh,
        input  rdata, rvalid, full, empty, overflow, underflow, level, thresh_hit
    );

    modport slave (
        input  wen, wdata, ren, clear, flag_clr, thresh,
        output rdata, rvalid, full, empty, overflow, underflow, level, thresh_hit
    );
endinterface

// File: rtl/spi_fifo_param.sv
// Synchronous FIFO with registered pop data, sticky overflow/underflow flags.
// Optional threshold detector enabled by defining SPI_FIFO_LEVEL_EN.
module spi_fifo_param #(
    parameter int DATA_WIDTH = 32,
    parameter int PTR_WIDTH  = 6
) (
    input  logic               pclk,
    input  logic               preset_n,
    spi_fifo_param_if.slave    bus
);
    localparam int DEPTH = 2 ** PTR_WIDTH;
    localparam logic [PTR_WIDTH:0] DEPTH_LVL = {1'b1, {PTR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH:0]    wr_ptr;
    logic [PTR_WIDTH:0]    rd_ptr;
    logic [PTR_WIDTH:0]    level_w;
    logic                  full_w;
    logic                  empty_w;
    logic                  pop_ok;
    logic                  push_ok;
    logic                  ovf_evt;
    logic                  unf_evt;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvalid_q;
    logic                  overflow_q;
    logic                  underflow_q;

    // Status depends only on the pointer registers.
    always_comb begin
        level_w = wr_ptr - rd_ptr;
        full_w  = (level_w == DEPTH_LVL);
        empty_w = (wr_ptr == rd_ptr);
    end

    always_comb begin
        pop_ok  = bus.ren & ~empty_w;
        push_ok = bus.wen & (~full_w | pop_ok);
        ovf_evt = bus.wen & full_w & ~pop_ok;
        unf_evt = bus.ren & empty_w;
    end

    // When full with a concurrent pop, the write lands in the slot being read;
    // the read samples the old head before the write takes effect.
    always_ff @(posedge pclk) begin
        if (push_ok && !bus.clear) begin
            mem[wr_ptr[PTR_WIDTH-1:0]] <= bus.wdata;
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (bus.clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rvalid_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rdata_q <= mem[rd_ptr[PTR_WIDTH-1:0]];
            end
            rvalid_q <= pop_ok;
            // A set event takes priority over a coincident flag_clr.
            if (ovf_evt) begin
                overflow_q <= 1'b1;
            end else if (bus.flag_clr) begin
                overflow_q <= 1'b0;
            end
            if (unf_evt) begin
                underflow_q <= 1'b1;
            end else if (bus.flag_clr) begin
                underflow_q <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.rdata     = rdata_q;
        bus.rvalid    = rvalid_q;
        bus.full      = full_w;
        bus.empty     = empty_w;
        bus.overflow  = overflow_q;
        bus.underflow = underflow_q;
        bus.level     = level_w;
`ifdef SPI_FIFO_LEVEL_EN
        bus.thresh_hit = (bus.thresh != '0) && (level_w >= bus.thresh);
`else
        bus.thresh_hit = 1'b0;
`endif
    end
endmodule

// File: tb/tb_spi_fifo_param.sv
// Directed bench for spi_fifo_param (DATA_WIDTH=32, PTR_WIDTH=6).
// Threshold expectations follow SPI_FIFO_LEVEL_EN as defined for this build.
module tb_spi_fifo_param;
    localparam int DW = 32;
    localparam int PW = 6;
`ifdef SPI_FIFO_LEVEL_EN
    localparam logic LVL_EN = 1'b1;
`else
    localparam logic LVL_EN = 1'b0;
`endif

    logic pclk;
    logic preset_n;
    int   n_vec;
    int   n_err;

    spi_fifo_param_if #(.DATA_WIDTH(DW), .PTR_WIDTH(PW)) bus ();

    spi_fifo_param #(.DATA_WIDTH(DW), .PTR_WIDTH(PW)) dut (
        .pclk     (pclk),
        .preset_n (preset_n),
        .bus      (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are stable 1ns later.
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic idle();
        bus.wen = 1'b0; bus.ren = 1'b0; bus.clear = 1'b0; bus.flag_clr = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] d);
        bus.wen = 1'b1; bus.wdata = d; bus.ren = 1'b0;
        tick();
        bus.wen = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        idle();
        bus.wdata  = '0;
        bus.thresh = 7'd8;
        preset_n   = 1'b0;
        #12;
        check("rst_empty", bus.empty, 1);
        check("rst_full", bus.full, 0);
        check("rst_level", bus.level, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_rvalid", bus.rvalid, 0);
        check("rst_ovf", bus.overflow, 0);
        check("rst_unf", bus.underflow, 0);
        check("rst_thit", bus.thresh_hit, 0);
        preset_n = 1'b1;
        tick();

        // Fill to full, then one dropped write.
        for (int i = 0; i < 64; i++) begin
            push(DW'(i));
            if (i == 6) check("thit_at7", bus.thresh_hit, 0);
            if (i == 7) check("thit_at8", bus.thresh_hit, {63'd0, LVL_EN});
        end
        check("fill_full", bus.full, 1);
        check("fill_level", bus.level, 64);
        check("fill_ovf", bus.overflow, 0);
        push(32'hFF);
        check("ovf_set", bus.overflow, 1);
        check("ovf_level", bus.level, 64);
        for (int i = 0; i < 64; i++) begin
            bus.ren = 1'b1;
            tick();
            check("drain_rdata", bus.rdata, i);
            check("drain_rvalid", bus.rvalid, 1);
        end
        idle();
        tick();
        check("drain_rvalid0", bus.rvalid, 0);
        check("drain_empty", bus.empty, 1);
        check("drain_rdata_hold", bus.rdata, 32'h3F);
        check("drain_unf", bus.underflow, 0);
        bus.flag_clr = 1'b1;
        tick();
        bus.flag_clr = 1'b0;
        check("flagclr_ovf", bus.overflow, 0);

        // Read on empty with a simultaneous write.
        bus.ren = 1'b1; bus.wen = 1'b1; bus.wdata = 32'hA5A5A5A5;
        tick();
        idle();
        check("unf_set", bus.underflow, 1);
        check("unf_rvalid", bus.rvalid, 0);
        check("unf_level", bus.level, 1);
        check("unf_rdata_hold", bus.rdata, 32'h3F);
        bus.ren = 1'b1;
        tick();
        idle();
        check("unf_pop_data", bus.rdata, 32'hA5A5A5A5);
        check("unf_pop_valid", bus.rvalid, 1);

        // Set event coincident with flag_clr keeps the flag set.
        bus.ren = 1'b1; bus.flag_clr = 1'b1;
        tick();
        idle();
        check("set_wins", bus.underflow, 1);
        bus.flag_clr = 1'b1;
        tick();
        idle();
        check("unf_cleared", bus.underflow, 0);

        // Push and pop together while full.
        for (int i = 0; i < 64; i++) push(32'h100 + DW'(i));
        bus.wen = 1'b1; bus.wdata = 32'h12345678; bus.ren = 1'b1;
        tick();
        idle();
        check("fullrw_level", bus.level, 64);
        check("fullrw_ovf", bus.overflow, 0);
        check("fullrw_rdata", bus.rdata, 32'h100);
        check("fullrw_rvalid", bus.rvalid, 1);
        for (int i = 1; i < 64; i++) begin
            bus.ren = 1'b1;
            tick();
            check("fullrw_drain", bus.rdata, 32'h100 + i);
        end
        tick();
        idle();
        check("fullrw_last", bus.rdata, 32'h12345678);
        check("fullrw_empty", bus.empty, 1);

        // Clear overrides wen/ren and flushes flags.
        bus.ren = 1'b1;
        tick();
        idle();
        check("pre_clr_unf", bus.underflow, 1);
        for (int i = 0; i < 10; i++) push(32'h200 + DW'(i));
        check("pre_clr_level", bus.level, 10);
        bus.clear = 1'b1; bus.wen = 1'b1; bus.ren = 1'b1; bus.wdata = 32'hDEAD;
        tick();
        idle();
        check("clr_level", bus.level, 0);
        check("clr_empty", bus.empty, 1);
        check("clr_rvalid", bus.rvalid, 0);
        check("clr_unf", bus.underflow, 0);
        check("clr_ovf", bus.overflow, 0);
        check("clr_rdata_hold", bus.rdata, 32'h12345678);

        // Asynchronous reset in the middle of a push sequence.
        for (int i = 0; i < 5; i++) push(32'h300 + DW'(i));
        bus.ren = 1'b1;
        tick();
        idle();
        check("prerst_rdata", bus.rdata, 32'h300);
        bus.wen = 1'b1; bus.wdata = 32'h305;
        #2;
        preset_n = 1'b0;
        #1;
        check("arst_level", bus.level, 0);
        check("arst_empty", bus.empty, 1);
        check("arst_rdata", bus.rdata, 0);
        tick();
        idle();
        preset_n = 1'b1;
        tick();
        push(32'h77);
        bus.ren = 1'b1;
        tick();
        idle();
        check("postrst_rdata", bus.rdata, 32'h77);
        check("postrst_empty", bus.empty, 1);

        // Threshold disabled when thresh is zero.
        bus.thresh = '0;
        push(32'h1);
        check("thit_zero", bus.thresh_hit, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
